// File: rtl/raiz_pkg.sv
// Shared definitions for the raiz square-root peripheral: register map,
// control/status bit positions and the root engine state encoding.
package raiz_pkg;

    localparam int unsigned ADDR_OP_LO  = 32'h0000_0004;
    localparam int unsigned ADDR_OP_HI  = 32'h0000_0008;
    localparam int unsigned ADDR_CTRL   = 32'h0000_000C;
    localparam int unsigned ADDR_RESULT = 32'h0000_0010;
    localparam int unsigned ADDR_REM    = 32'h0000_0014;
    localparam int unsigned ADDR_STATUS = 32'h0000_0018;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;

    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_OVR  = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } raiz_state_e;

endpackage

// File: rtl/raiz_iter_core.sv
// Restoring integer square-root engine: one root bit per clock, result and
// remainder registers only change when a computation completes.
module raiz_iter_core
    import raiz_pkg::*;
#(
    parameter int OP_W = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    output logic              busy,
    output logic              done_pulse,
    output logic [OP_W/2-1:0] root,
    output logic [OP_W/2:0]   rem
);

    localparam int RW = OP_W / 2;
    localparam int CW = $clog2(RW + 1);
    localparam int TW = RW + 3;

    raiz_state_e   state_q, state_d;
    logic [OP_W-1:0] rad_q, rad_d;
    logic [RW-1:0]   proot_q, proot_d;
    logic [RW:0]     prem_q, prem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   root_q, root_d;
    logic [RW:0]     rem_q, rem_d;
    logic [TW-1:0]   rem_t_s, trial_s, diff_s;

    // Next-state: snapshot on start, then one trial subtraction per clock
    always_comb begin
        state_d = state_q;
        rad_d   = rad_q;
        proot_d = proot_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        root_d  = root_q;
        rem_d   = rem_q;
        rem_t_s = {prem_q, rad_q[OP_W-1 -: 2]};
        trial_s = {1'b0, proot_q, 2'b01};
        diff_s  = rem_t_s - trial_s;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    rad_d   = op;
                    cnt_d   = CW'(RW);
                    proot_d = '0;
                    prem_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                rad_d = {rad_q[OP_W-3:0], 2'b00};
                // The remainder never exceeds twice the root, so RW+1 bits hold it
                if (rem_t_s >= trial_s) begin
                    prem_d  = diff_s[RW:0];
                    proot_d = {proot_q[RW-2:0], 1'b1};
                end else begin
                    prem_d  = rem_t_s[RW:0];
                    proot_d = {proot_q[RW-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    root_d  = proot_d;
                    rem_d   = prem_d;
                end else begin
                    state_d = ST_CALC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Engine state registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rad_q   <= '0;
            proot_q <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rad_q   <= rad_d;
            proot_q <= proot_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
        end
    end

    assign busy       = (state_q == ST_CALC);
    assign done_pulse = (state_q == ST_CALC) && (cnt_q == CW'(1));
    assign root       = root_q;
    assign rem        = rem_q;

endmodule

// File: rtl/raiz_bus_param.sv
// Bus-mapped square-root peripheral: operand/control registers, sticky
// done/overrun flags, level interrupt and registered read port.
module raiz_bus_param
    import raiz_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [DATA_W-1:0] d_in,
    input  logic              cs,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] d_out,
    output logic              irq
);

    localparam int HI_W = (OP_W > DATA_W) ? (OP_W - DATA_W) : 1;
    localparam int RW   = OP_W / 2;
    localparam bit HAS_HI = (OP_W > DATA_W);

    localparam logic [ADDR_W-1:0] A_OP_LO  = ADDR_W'(ADDR_OP_LO);
    localparam logic [ADDR_W-1:0] A_OP_HI  = ADDR_W'(ADDR_OP_HI);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ADDR_CTRL);
    localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(ADDR_RESULT);
    localparam logic [ADDR_W-1:0] A_REM    = ADDR_W'(ADDR_REM);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADDR_STATUS);

    logic [DATA_W-1:0]      op_lo_q, op_lo_d;
    logic [HI_W-1:0]        op_hi_q, op_hi_d;
    logic                   irq_en_q, irq_en_d;
    logic                   done_q, done_d;
    logic                   ovr_q, ovr_d;
    logic                   irq_q, irq_d;
    logic [DATA_W-1:0]      d_out_q, d_out_d;
    logic [DATA_W-1:0]      rdata_s;
    logic                   start_s, start_ok_s, clr_s;
    logic                   busy_s, done_pulse_s;
    logic [RW-1:0]          root_s;
    logic [RW:0]            rem_s;
    logic [HI_W+DATA_W-1:0] op_full_s;

    assign op_full_s = {op_hi_q, op_lo_q};

    raiz_iter_core #(
        .OP_W (OP_W)
    ) u_core (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start_ok_s),
        .op         (op_full_s[OP_W-1:0]),
        .busy       (busy_s),
        .done_pulse (done_pulse_s),
        .root       (root_s),
        .rem        (rem_s)
    );

    // Bus decode, register writes and flag updates
    always_comb begin
        op_lo_d  = op_lo_q;
        op_hi_d  = op_hi_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        ovr_d    = ovr_q;
        start_s  = 1'b0;
        clr_s    = 1'b0;
        rdata_s  = '0;
        case (addr)
            A_OP_LO:  rdata_s = op_lo_q;
            A_OP_HI:  rdata_s = HAS_HI ? DATA_W'(op_hi_q) : '0;
            A_CTRL:   rdata_s[CTRL_IRQ_EN] = irq_en_q;
            A_RESULT: rdata_s = DATA_W'(root_s);
            A_REM:    rdata_s = DATA_W'(rem_s);
            A_STATUS: begin
                rdata_s[STAT_DONE] = done_q;
                rdata_s[STAT_BUSY] = busy_s;
                rdata_s[STAT_OVR]  = ovr_q;
            end
            default:  rdata_s = '0;
        endcase
        // Read data is sampled from pre-write register values
        if (cs && rd) begin
            d_out_d = rdata_s;
        end else begin
            d_out_d = d_out_q;
        end
        if (cs && wr) begin
            case (addr)
                A_OP_LO: op_lo_d = d_in;
                A_OP_HI: op_hi_d = d_in[HI_W-1:0];
                A_CTRL: begin
                    irq_en_d = d_in[CTRL_IRQ_EN];
                    start_s  = d_in[CTRL_START];
                    clr_s    = d_in[CTRL_CLR];
                end
                default: op_lo_d = op_lo_q;
            endcase
        end else begin
            op_lo_d = op_lo_q;
        end
        start_ok_s = start_s && !busy_s;
        if (clr_s) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
        if (start_s && busy_s) begin
            ovr_d = 1'b1;
        end else begin
            ovr_d = ovr_d;
        end
        // Completion is applied last so it wins over a simultaneous CLR
        if (clr_s || start_ok_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
        if (done_pulse_s) begin
            done_d = 1'b1;
        end else begin
            done_d = done_d;
        end
        irq_d = done_q && irq_en_q;
    end

    // Peripheral register bank
    always_ff @(posedge CLK) begin
        if (reset) begin
            op_lo_q  <= '0;
            op_hi_q  <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
            d_out_q  <= '0;
        end else begin
            op_lo_q  <= op_lo_d;
            op_hi_q  <= op_hi_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_d;
            d_out_q  <= d_out_d;
        end
    end

    assign d_out = d_out_q;
    assign irq   = irq_q;

endmodule
